ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (LED set, reset, echo) to the keyboard.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_line_sync.sv | 54 +++++
 rtl/ps2_host_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions: FSM state encoding, keyboard
// command/response byte constants and small helpers used by ps2_host_tx.
package ps2_pkg;

   // Transmitter FSM states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      DATA      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5,
      FAIL      = 3'd6
   } tx_state_t;

   // Host-to-keyboard commands and the device responses that follow them.
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RESP_ACK     = 8'hFA;
   localparam logic [7:0] RESP_RESEND  = 8'hFE;

   // Falling-edge numbers that mark the end of the frame on the wire.
   localparam logic [3:0] EDGE_PARITY = 4'd9;
   localparam logic [3:0] EDGE_STOP   = 4'd10;

   // PS/2 frames carry odd parity over the data byte.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

   // Microseconds to system clock cycles (clock assumed an integer number of MHz).
   function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                input int unsigned us);
      return (clk_hz / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the raw PS/2 clock and data levels into the system clock domain
// through two flops each, and flags a PS2_CLK falling edge for one cycle.
// Flops reset to 1 (idle bus level) so reset never fakes a falling edge.
module ps2_line_sync (
   input  logic clock,
   input  logic reset,
   input  logic clk_in,
   input  logic dat_in,
   output logic clk_sync,
   output logic dat_sync,
   output logic clk_fall
);

   logic [1:0] raw_vec;
   logic [1:0] sync_vec;
   logic       clk_prev_reg;

   assign raw_vec = {dat_in, clk_in};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;

         // Two-stage synchronizer for one line.
         always_ff @(posedge clock) begin
            if (reset) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
            end else begin
               meta_reg <= raw_vec[gi];
               sync_reg <= meta_reg;
            end
         end

         assign sync_vec[gi] = sync_reg;
      end
   endgenerate

   // Remember last synchronized clock level for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_prev_reg <= 1'b1;
      end else begin
         clk_prev_reg <= sync_vec[0];
      end
   end

   assign clk_sync = sync_vec[0];
   assign dat_sync = sync_vec[1];
   assign clk_fall = clk_prev_reg & ~sync_vec[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard on
// the shared PS2_CLK/PS2_DAT pair using active-high pull-low enables
// (open-drain at the pad: PS2_x = oe ? 1'b0 : 1'bz).
// Optional feature macro: PS2_TX_RETRY_EN -- when defined, a failed frame is
// re-sent from INHIBIT up to MAX_RETRY times before error is reported.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
   parameter int unsigned INHIBIT_US   = 120,
   parameter int unsigned START_TMO_US = 15000,
   parameter int unsigned BIT_TMO_US   = 2000,
   parameter int unsigned MAX_RETRY    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int unsigned INHIBIT_CYC   = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
   localparam int unsigned START_TMO_CYC = us_to_cycles(CLK_FREQ_HZ, START_TMO_US);
   localparam int unsigned BIT_TMO_CYC   = us_to_cycles(CLK_FREQ_HZ, BIT_TMO_US);
   localparam int          WD_W          = $clog2(START_TMO_CYC + 1);
   localparam int          INH_W         = $clog2(INHIBIT_CYC + 1);

   localparam logic [WD_W-1:0]  START_LOAD = WD_W'(START_TMO_CYC);
   localparam logic [WD_W-1:0]  BIT_LOAD   = WD_W'(BIT_TMO_CYC);
   localparam logic [WD_W-1:0]  WD_ONE     = WD_W'(1);
   localparam logic [INH_W-1:0] INH_LOAD   = INH_W'(INHIBIT_CYC - 1);

   // Synchronized line levels and falling edge of the device clock.
   logic clk_sync;
   logic dat_sync;
   logic clk_fall;

   ps2_line_sync u_line_sync (
      .clock    (clock),
      .reset    (reset),
      .clk_in   (ps2_clk_in),
      .dat_in   (ps2_dat_in),
      .clk_sync (clk_sync),
      .dat_sync (dat_sync),
      .clk_fall (clk_fall)
   );

   tx_state_t        state_reg,    state_next;
   logic             clk_oe_reg,   clk_oe_next;
   logic             dat_oe_reg,   dat_oe_next;
   logic [7:0]       data_reg,     data_next;
   logic             parity_reg,   parity_next;
   logic [INH_W-1:0] inh_cnt_reg,  inh_cnt_next;
   logic [WD_W-1:0]  wd_reg,       wd_next;
   logic [3:0]       edge_cnt_reg, edge_cnt_next;
   logic [3:0]       edge_num;
   logic [WD_W-1:0]  wd_dec;
   logic             done_pulse;
   logic             error_pulse;

`ifdef PS2_TX_RETRY_EN
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RTY_W-1:0] retry_reg, retry_next;
`else
   // MAX_RETRY only matters when retries are built in.
   logic unused_max_retry;
   assign unused_max_retry = |MAX_RETRY;
`endif

   // Next-state, line drive and counter logic.
   always_comb begin
      state_next    = state_reg;
      clk_oe_next   = clk_oe_reg;
      dat_oe_next   = dat_oe_reg;
      data_next     = data_reg;
      parity_next   = parity_reg;
      inh_cnt_next  = inh_cnt_reg;
      wd_next       = wd_reg;
      edge_cnt_next = edge_cnt_reg;
      done_pulse    = 1'b0;
      error_pulse   = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_next    = retry_reg;
`endif
      edge_num = edge_cnt_reg + 4'd1;
      // Watchdog saturates at zero rather than wrapping.
      wd_dec   = (wd_reg != '0) ? (wd_reg - WD_ONE) : '0;

      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               data_next     = cmd_data;
               parity_next   = odd_parity(cmd_data);
               clk_oe_next   = 1'b1;
               dat_oe_next   = 1'b0;
               inh_cnt_next  = INH_LOAD;
               edge_cnt_next = '0;
`ifdef PS2_TX_RETRY_EN
               retry_next    = '0;
`endif
               state_next    = INHIBIT;
            end
         end

         INHIBIT: begin
            // Hand the clock back and assert the start bit on the same edge.
            if (inh_cnt_reg == '0) begin
               clk_oe_next   = 1'b0;
               dat_oe_next   = 1'b1;
               wd_next       = START_LOAD;
               edge_cnt_next = '0;
               state_next    = REQ;
            end else begin
               inh_cnt_next = inh_cnt_reg - 1'b1;
            end
         end

         REQ, DATA: begin
            if (clk_fall) begin
               edge_cnt_next = edge_num;
               wd_next       = BIT_LOAD;
               state_next    = DATA;
               if (edge_num <= 4'd8) begin
                  dat_oe_next = ~data_reg[3'(edge_num - 4'd1)];
               end else if (edge_num == EDGE_PARITY) begin
                  dat_oe_next = ~parity_reg;
               end else begin
                  // Stop bit: release the line so the device can ack.
                  dat_oe_next = 1'b0;
                  state_next  = ACK;
               end
            end else if (wd_reg <= WD_ONE) begin
               clk_oe_next = 1'b0;
               dat_oe_next = 1'b0;
               state_next  = FAIL;
            end else begin
               wd_next = wd_dec;
            end
         end

         ACK: begin
            // Edge 11: device must be holding data low.
            if (clk_fall) begin
               edge_cnt_next = edge_num;
               wd_next       = BIT_LOAD;
               state_next    = dat_sync ? FAIL : WAIT_IDLE;
            end else if (wd_reg <= WD_ONE) begin
               state_next = FAIL;
            end else begin
               wd_next = wd_dec;
            end
         end

         WAIT_IDLE: begin
            // Further falls are ignored; only wait for the bus to go idle.
            if (clk_sync && dat_sync) begin
               done_pulse = 1'b1;
               state_next = IDLE;
            end else if (wd_reg <= WD_ONE) begin
               state_next = FAIL;
            end else begin
               wd_next = wd_dec;
            end
         end

         FAIL: begin
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_reg < RTY_W'(MAX_RETRY)) begin
               retry_next    = retry_reg + 1'b1;
               clk_oe_next   = 1'b1;
               inh_cnt_next  = INH_LOAD;
               edge_cnt_next = '0;
               state_next    = INHIBIT;
            end else begin
               error_pulse = 1'b1;
               state_next  = IDLE;
            end
`else
            error_pulse = 1'b1;
            state_next  = IDLE;
`endif
         end

         default: begin
            clk_oe_next = 1'b0;
            dat_oe_next = 1'b0;
            state_next  = IDLE;
         end
      endcase
   end

   // State, line-enable and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         clk_oe_reg   <= 1'b0;
         dat_oe_reg   <= 1'b0;
         data_reg     <= '0;
         parity_reg   <= 1'b0;
         inh_cnt_reg  <= '0;
         wd_reg       <= '0;
         edge_cnt_reg <= '0;
`ifdef PS2_TX_RETRY_EN
         retry_reg    <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         clk_oe_reg   <= clk_oe_next;
         dat_oe_reg   <= dat_oe_next;
         data_reg     <= data_next;
         parity_reg   <= parity_next;
         inh_cnt_reg  <= inh_cnt_next;
         wd_reg       <= wd_next;
         edge_cnt_reg <= edge_cnt_next;
`ifdef PS2_TX_RETRY_EN
         retry_reg    <= retry_next;
`endif
      end
   end

   assign ps2_clk_oe = clk_oe_reg;
   assign ps2_dat_oe = dat_oe_reg;
   assign cmd_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign done       = done_pulse;
   assign error      = error_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models a keyboard (80-cycle device clock, samples
// data on its rising edge) with the DUT scaled to a 1 MHz system clock so
// all time constants are in cycles = microseconds.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned CLK_HZ    = 1_000_000;
   localparam int          INH       = 120;
   localparam int          START_TMO = 15000;
   localparam int          BIT_TMO   = 2000;
   localparam int          HALF      = 40;

   logic       clock     = 1'b0;
   logic       reset     = 1'b1;
   logic [7:0] cmd_data  = 8'h00;
   logic       cmd_valid = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       cmd_ready, ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       busy, done, error;

   // Wired-AND bus: either side may pull a line low.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_host_tx #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .INHIBIT_US   (120),
      .START_TMO_US (15000),
      .BIT_TMO_US   (2000),
      .MAX_RETRY    (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;
   int     done_hi = 0;
   int     err_hi  = 0;
   int     inh_rise = 0;
   logic   clk_oe_prev = 1'b0;
   logic [9:0] exp_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   // Pulse and inhibit-phase counters, sampled away from the active edge.
   always @(negedge clock) begin
      if (done)  done_hi <= done_hi + 1;
      if (error) err_hi  <= err_hi + 1;
      if (ps2_clk_oe && !clk_oe_prev) inh_rise <= inh_rise + 1;
      clk_oe_prev <= ps2_clk_oe;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1, "bench time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Present a byte, optionally record its expected wire bits, measure inhibit.
   task automatic send_cmd(input logic [7:0] b, input bit sb, output int inh_cycles);
      int n;
      cmd_data  = b;
      cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
      if (sb) exp_q.push_back({1'b1, ~^b, b});
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         tick(1);
      end
      inh_cycles = n;
   endtask

   // Keyboard model: generate nedges clock pulses, sample data at each rise.
   task automatic device_frame(input int nedges, input bit do_ack,
                               output logic [9:0] bits, output longint last_fall);
      bits      = '0;
      last_fall = 0;
      tick(20);
      for (int k = 1; k <= nedges; k++) begin
         dev_clk_low = 1'b1;
         last_fall   = cyc;
         tick(HALF);
         if (k <= 10) bits[k-1] = ps2_dat_in;
         dev_clk_low = 1'b0;
         if (k == 11) dev_dat_low = 1'b0;
         if (k < nedges) begin
            tick(HALF / 2);
            if (k == 10 && do_ack) dev_dat_low = 1'b1;
            tick(HALF / 2);
         end
      end
   endtask

   task automatic check_frame(input string tag, input logic [9:0] bits);
      logic [9:0] exp;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         exp = exp_q.pop_front();
         chk({tag, "_bits"}, 32'(bits), 32'(exp));
      end
   endtask

   task automatic run_ok_frame(input logic [7:0] b, input string tag);
      int n, d0, e0;
      logic [9:0] bits;
      longint lf;
      d0 = done_hi;
      e0 = err_hi;
      send_cmd(b, 1'b1, n);
      chk({tag, "_inhibit_len"}, 32'(n), 32'(INH));
      chk({tag, "_start_bit"}, 32'(ps2_dat_oe), 32'd1);
      device_frame(11, 1'b1, bits, lf);
      check_frame(tag, bits);
      n = 0;
      while (!done && n < 200) begin
         tick(1);
         n++;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      tick(1);
      chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
      tick(5);
      chk({tag, "_done_count"}, 32'(done_hi - d0), 32'd1);
      chk({tag, "_error_count"}, 32'(err_hi - e0), 32'd0);
   endtask

   initial begin
      int n, m, d0, e0, i0;
      logic [9:0] bits;
      longint lf;

      // Reset, with cmd_valid asserted at the same time.
      reset     = 1'b1;
      cmd_valid = 1'b1;
      tick(3);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      cmd_valid = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(2);

      // Normal frames with different parity outcomes.
      run_ok_frame(CMD_SET_LEDS, "set_leds");
      run_ok_frame(CMD_ENABLE, "enable");
      run_ok_frame(8'h00, "zero");

`ifndef PS2_TX_RETRY_EN
      // Device never clocks: start timeout.
      d0 = done_hi;
      e0 = err_hi;
      send_cmd(CMD_ECHO, 1'b0, n);
      chk("nodev_inhibit_len", 32'(n), 32'(INH));
      m = 0;
      while (!error && m < START_TMO + 100) begin
         tick(1);
         m++;
      end
      chk("nodev_start_tmo", 32'(m), 32'(START_TMO));
      tick(1);
      chk("nodev_error_1cyc", 32'(error), 32'd0);
      chk("nodev_ready", 32'(cmd_ready), 32'd1);
      tick(3);
      chk("nodev_error_count", 32'(err_hi - e0), 32'd1);
      chk("nodev_done_count", 32'(done_hi - d0), 32'd0);

      // Device stops after edge 5: bit timeout.
      e0 = err_hi;
      send_cmd(CMD_RESET, 1'b0, n);
      device_frame(5, 1'b1, bits, lf);
      m = 0;
      while (!error && m < BIT_TMO + 100) begin
         tick(1);
         m++;
      end
      chk("stall_bit_tmo", 32'((cyc - lf >= BIT_TMO) && (cyc - lf <= BIT_TMO + 6)), 32'd1);
      chk("stall_lines_free", 32'(ps2_clk_oe | ps2_dat_oe), 32'd0);
      tick(3);
      chk("stall_error_count", 32'(err_hi - e0), 32'd1);

      // Ack bit left high.
      d0 = done_hi;
      e0 = err_hi;
      send_cmd(CMD_ENABLE, 1'b1, n);
      device_frame(11, 1'b0, bits, lf);
      check_frame("noack", bits);
      tick(20);
      chk("noack_error_count", 32'(err_hi - e0), 32'd1);
      chk("noack_done_count", 32'(done_hi - d0), 32'd0);
      chk("noack_ready", 32'(cmd_ready), 32'd1);
`endif

      // Reset during edge 4 of a frame.
      d0 = done_hi;
      e0 = err_hi;
      send_cmd(CMD_ENABLE, 1'b0, n);
      device_frame(3, 1'b1, bits, lf);
      tick(HALF);
      dev_clk_low = 1'b1;
      tick(10);
      chk("midrst_pre_dat_oe", 32'(ps2_dat_oe), 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      dev_clk_low = 1'b0;
      tick(200);
      chk("midrst_done_count", 32'(done_hi - d0), 32'd0);
      chk("midrst_error_count", 32'(err_hi - e0), 32'd0);

      // cmd_valid held high for the whole frame: exactly one frame.
      d0 = done_hi;
      i0 = inh_rise;
      cmd_data  = CMD_ECHO;
      cmd_valid = 1'b1;
      exp_q.push_back({1'b1, ~^CMD_ECHO, CMD_ECHO});
      tick(1);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         tick(1);
      end
      chk("held_inhibit_len", 32'(n), 32'(INH));
      device_frame(11, 1'b1, bits, lf);
      check_frame("held", bits);
      n = 0;
      while (!done && n < 200) begin
         tick(1);
         n++;
      end
      chk("held_done", 32'(done), 32'd1);
      cmd_valid = 1'b0;
      tick(300);
      chk("held_inhibit_count", 32'(inh_rise - i0), 32'd1);
      chk("held_done_count", 32'(done_hi - d0), 32'd1);
      chk("held_ready", 32'(cmd_ready), 32'd1);

`ifdef PS2_TX_RETRY_EN
      // Ack high on every attempt: three inhibit phases, one error.
      e0 = err_hi;
      i0 = inh_rise;
      send_cmd(CMD_ECHO, 1'b0, n);
      for (int a = 0; a < 3; a++) begin
         if (a > 0) begin
            m = 0;
            while (!ps2_clk_oe && m < 200) begin
               tick(1);
               m++;
            end
            while (ps2_clk_oe && m < 1200) begin
               tick(1);
               m++;
            end
         end
         chk("retry_busy", 32'(busy), 32'd1);
         device_frame(11, 1'b0, bits, lf);
      end
      tick(20);
      chk("retry_inhibit_count", 32'(inh_rise - i0), 32'd3);
      chk("retry_error_count", 32'(err_hi - e0), 32'd1);
      chk("retry_busy_end", 32'(busy), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
